led_count_ctrl: RTL
===================

# led_count_ctrl

Sequencing controller for the LED up/down counter datapath on the ECP3 Versa LED test design. It prescales the 100 MHz board clock into one-cycle count enables and drives the counter's `direction` input. It also implements four run modes (stop, up, down, bounce) and a debounced single-step button. The block sits between the board switches/buttons and the counter: it issues `tick`/`direction`, and reads the counter's current value back on `count_in`.

## Interface
- `PRESCALE`, default 25_000_000: clock cycles per tick period. Legal range ≥ 3; use 4 in simulation.
- `CNT_W`, default 8: width of the counter value fed back on `count_in`.
- `clk`  in  1: board clock, 100 MHz. This is the only clock.
- `reset`  in  1: synchronous, active-high.
- `mode`  in  2: run mode. 0 = STOP, 1 = UP, 2 = DOWN, 3 = BOUNCE. Asynchronous to the design; resynchronised internally.
- `step_btn`  in  1: raw push button, active-high, asynchronous.
- `count_in`  in  CNT_W: registered counter value from the datapath.
- `tick`  out  1: one-cycle count enable to the datapath.
- `direction`  out  1: 1 = count up, 0 = count down. Registered.
- `running`  out  1: high when the FSM is in RUN_UP or RUN_DOWN.

## Operation
- **Input synchronisers.**
  - `mode` and `step_btn` each pass through a 2-flop synchroniser.
  - `step_btn` then gets rising-edge detection, giving `step_pulse`.
- **Prescaler.**
  - `pre_q` free-runs from 0 to PRESCALE-1 and then wraps to 0.
  - It is never stalled by mode changes.
- **FSM states:** IDLE, RUN_UP, RUN_DOWN, STEP.
  - Transitions are evaluated only when `pre_q` == PRESCALE-1 (the "wrap"), except IDLE→STEP.
  - At wrap, the synchronised mode selects the next state:
    - STOP → IDLE.
    - UP → RUN_UP.
    - DOWN → RUN_DOWN.
    - BOUNCE → RUN_UP or RUN_DOWN, according to the current `direction`.
  - IDLE with `step_pulse` → STEP. STEP always returns to IDLE on the next cycle.
  - `step_pulse` in any other state is ignored; it is not queued.
- **`tick` generation.**
  - `tick` = 1 in the wrap cycle when the state is RUN_UP or RUN_DOWN.
  - `tick` = 1 for the single cycle spent in STEP.
  - Otherwise `tick` = 0.
- **`direction` update.** Registered, updated only when `pre_q` == PRESCALE-2:
  - UP: `direction` = 1.
  - DOWN: `direction` = 0.
  - BOUNCE, `direction` = 1 and `count_in` == 2^CNT_W-1: `direction` becomes 0.
  - BOUNCE, `direction` = 0 and `count_in` == 0: `direction` becomes 1.
  - BOUNCE, otherwise: `direction` holds.
  - STOP: `direction` holds.
- **Step direction.** Steps use the held `direction`.
- **Reset mid-operation.** Reset forces state, prescaler and synchronisers to reset values on the next edge. Any tick that would have fired in that cycle is suppressed.

## Timing
- **Reset values:**
  - `tick` = 0, `direction` = 1, `running` = 0.
  - State = IDLE, `pre_q` = 0.
  - Synchroniser and edge-detect flops = 0.
- **Tick period.** In the run states, ticks are exactly PRESCALE cycles apart.
- **First tick after reset** with `mode` held at UP: the cycle where `pre_q` == PRESCALE-1 of the second prescaler period. The first wrap only moves IDLE → RUN_UP, and that wrap does not tick.
- **Mode latency.** Mode changes take effect 2 sync cycles plus up to PRESCALE cycles later, always at a wrap.
- **Step latency.** A button rising edge produces `tick` 4 cycles later: 2 sync cycles + edge-detect register + STEP state.
  - Exactly one tick per press.
  - The button must fall and rise again before the next step.
- **Direction setup.** `direction` changes at least 1 cycle before any `tick`, so it is stable on every tick cycle.
- **Datapath settling.** `count_in` must settle within PRESCALE-2 cycles after a tick. The datapath's 1-cycle update meets this for PRESCALE ≥ 3.

## Structure
- **Shared package `led_ctrl_pkg`:**
  - Mode encodings: MODE_STOP, MODE_UP, MODE_DOWN, MODE_BOUNCE.
  - FSM state enum.
  - DIR_UP = 1, DIR_DOWN = 0.
- **Sub-module `sync_edge`:** a 2-flop synchroniser plus rising-edge detector, parameterised by width. Instantiate it for `step_btn`, and use its sync path for `mode`.
- **Top level:** the prescaler, FSM and direction logic stay in `led_count_ctrl`.

## Test plan
All scenarios use PRESCALE = 4 and CNT_W = 4, driven against the real counter datapath.

1. **Reset values.** Hold `reset` for 10 cycles with `mode` = UP → `tick` = 0, `direction` = 1, `running` = 0 throughout. After release, the first tick comes after two full prescaler periods; the following ticks are every 4 cycles and the count goes 0, 1, 2, 3.
2. **Down mode.** Set `mode` = DOWN from count 3 → `direction` goes to 0 before the next tick; the count goes 3, 2, 1, 0, 15 (wrap-around allowed in DOWN).
3. **Bounce at the top.** Set `mode` = BOUNCE starting at count 13 → the count goes 14, 15, 14, 13. `direction` drops exactly at `pre_q` == 2 of the period in which `count_in` = 15.
4. **Bounce at the bottom.** Run BOUNCE at count 1 going down → the count goes 0, 1, 2; there is never a wrap to 15.
5. **Single step.** In `mode` = STOP, press `step_btn` for 3 cycles, twice → exactly 2 ticks, each 4 cycles after its rising edge. A press while in UP mode adds no extra tick.
6. **Reset mid-run.** Assert `reset` in the cycle where `pre_q` == 3 while running → no tick in that cycle. All outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/led_count_ctrl_pkg.sv
// Shared encodings for the LED counter sequencing controller:
// run modes, direction values and FSM states.
package led_ctrl_pkg;

  localparam logic [1:0] MODE_STOP   = 2'd0;
  localparam logic [1:0] MODE_UP     = 2'd1;
  localparam logic [1:0] MODE_DOWN   = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2,
    ST_STEP     = 2'd3
  } ctrl_state_e;

  // State entered at a prescaler wrap for a given mode; BOUNCE follows the held direction.
  function automatic ctrl_state_e wrap_target(input logic [1:0] mode, input logic dir);
    ctrl_state_e st;
    st = ST_IDLE;
    case (mode)
      MODE_UP:     st = ST_RUN_UP;
      MODE_DOWN:   st = ST_RUN_DOWN;
      MODE_BOUNCE: st = (dir == DIR_UP) ? ST_RUN_UP : ST_RUN_DOWN;
      default:     st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/led_count_ctrl_if.sv
// Board-side bundle between switches/buttons, the counter datapath and the controller.
interface led_count_ctrl_if #(
  parameter int CNT_W = 8
);
  import led_ctrl_pkg::*;

  logic [1:0]       mode;
  logic             step_btn;
  logic [CNT_W-1:0] count_in;
  // tick is a one-cycle strobe with no back-pressure: the datapath must take every
  // tick using the direction presented in that same cycle.
  logic             tick;
  logic             direction;
  logic             running;
  ctrl_state_e      dbg_state;

  modport master (
    output mode, step_btn, count_in,
    input  tick, direction, running, dbg_state
  );

  modport slave (
    input  mode, step_btn, count_in,
    output tick, direction, running, dbg_state
  );

endinterface

// File: rtl/led_count_ctrl_sync_edge.sv
// Two-flop synchroniser per bit followed by a registered rising-edge detector.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_prev;
  logic [W-1:0] r_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_rise <= '0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_rise <= r_s2 & ~r_prev;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_rise;

endmodule

// File: rtl/led_count_ctrl.sv
// Prescaler, run-mode FSM and direction register driving the LED up/down counter.
module led_count_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int PRESCALE = 25_000_000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  led_count_ctrl_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_SETUP = PW'(PRESCALE - 2);

  logic [PW-1:0] r_pre_q;
  logic          r_direction;
  ctrl_state_e   r_state;

  ctrl_state_e   w_next_state;
  ctrl_state_e   w_wrap_state;
  logic          w_next_dir;
  logic          w_wrap;
  logic          w_setup;
  logic          w_running;
  logic [2:0]    w_sync;
  logic [2:0]    w_rise;
  logic [1:0]    w_mode;
  logic          w_step_pulse;

  // Bit 0 is the step button (edge used); bits 2:1 are the mode switches (level used).
  sync_edge #(.W(3)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    ({bus.mode, bus.step_btn}),
    .o_sync (w_sync),
    .o_rise (w_rise)
  );

  assign w_mode       = w_sync[2:1];
  assign w_step_pulse = w_rise[0];
  wire unused_sync    = &{1'b0, w_sync[0], w_rise[2:1]};

  assign w_wrap  = (r_pre_q == PRE_LAST);
  assign w_setup = (r_pre_q == PRE_SETUP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_q <= '0;
    end else if (w_wrap) begin
      r_pre_q <= '0;
    end else begin
      r_pre_q <= r_pre_q + PW'(1);
    end
  end

  // Direction settles one cycle ahead of the wrap so it is stable on every tick.
  always_comb begin
    w_next_dir = r_direction;
    case (w_mode)
      MODE_UP:   w_next_dir = DIR_UP;
      MODE_DOWN: w_next_dir = DIR_DOWN;
      MODE_BOUNCE: begin
        if (r_direction == DIR_UP && bus.count_in == '1) begin
          w_next_dir = DIR_DOWN;
        end else if (r_direction == DIR_DOWN && bus.count_in == '0) begin
          w_next_dir = DIR_UP;
        end
      end
      default: w_next_dir = r_direction;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_direction <= DIR_UP;
    end else if (w_setup) begin
      r_direction <= w_next_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_wrap_state = wrap_target(w_mode, r_direction);
    case (r_state)
      ST_IDLE: begin
        if (w_wrap && w_wrap_state != ST_IDLE) begin
          w_next_state = w_wrap_state;
        end else if (w_step_pulse) begin
          w_next_state = ST_STEP;
        end
      end
      ST_RUN_UP, ST_RUN_DOWN: begin
        if (w_wrap) begin
          w_next_state = w_wrap_state;
        end
      end
      ST_STEP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_running = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DOWN);

  // A tick due in the same cycle that reset is asserted is dropped.
  assign bus.tick      = ~reset & ((w_running & w_wrap) | (r_state == ST_STEP));
  assign bus.direction = r_direction;
  assign bus.running   = w_running;
  assign bus.dbg_state = r_state;

endmodule
